// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, register-address widths,
// fetch FSM encoding and default reset vector.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned INSTR_W_DEF = 32;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned RD_MSB  = 27;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS_MSB  = 21;
    localparam int unsigned RS_LSB  = 16;
    localparam int unsigned RT_MSB  = 15;
    localparam int unsigned RT_LSB  = 10;

    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned REG_ADDR_W = 6;
    localparam int unsigned CNT_W      = 32;

    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid-tagged, holds on stall, drops valid on flush.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic               valid_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q,    pc_d;

    // Load has priority; clear only drops the valid tag and keeps the payload.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (load_i) begin
            valid_d = valid_i;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem,
// handles redirect/stall and feeds the IF/ID register to decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]    imem_rdata,
    output logic                  id_valid,
    output logic [INSTR_W-1:0]    id_instr,
    output logic [ADDR_W-1:0]     id_pc,
    output logic [OPCODE_W-1:0]   id_opcode,
    output logic [REG_ADDR_W-1:0] id_rd,
    output logic [REG_ADDR_W-1:0] id_rs,
    output logic [REG_ADDR_W-1:0] id_rt,
    output logic [CNT_W-1:0]      fetch_count,
    output logic [CNT_W-1:0]      flush_count
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_f_q,  pc_f_d;
    logic              valid_f_q, valid_f_d;
    logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [ADDR_W-1:0] addr_c;
    logic              id_load_c;
    logic              id_clear_c;
    logic              id_valid_in_c;

    // Next-PC selection, IF/ID control and counter updates.
    always_comb begin
        state_d       = state_q;
        valid_f_d     = valid_f_q;
        fetch_cnt_d   = fetch_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        addr_c        = RESET_PC;
        id_load_c     = 1'b0;
        id_clear_c    = 1'b0;
        id_valid_in_c = 1'b0;

        case (state_q)
            BOOT: begin
                state_d    = RUN;
                valid_f_d  = 1'b1;
                id_clear_c = 1'b1;
            end
            RUN: begin
                if (redirect) begin
                    addr_c    = redirect_pc;
                    valid_f_d = 1'b1;
                    id_load_c = 1'b1;
                    if (valid_f_q || id_valid) begin
                        flush_cnt_d = flush_cnt_q + CNT_W'(1);
                    end
                end else if (stall) begin
                    // Re-fetch the same word so imem_rdata stays stable.
                    addr_c = pc_f_q;
                end else begin
                    addr_c        = pc_f_q + ADDR_W'(1);
                    id_load_c     = 1'b1;
                    id_valid_in_c = valid_f_q;
                    if (valid_f_q) begin
                        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        pc_f_d = addr_c;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BOOT;
            pc_f_q      <= RESET_PC;
            valid_f_q   <= 1'b0;
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_f_q      <= pc_f_d;
            valid_f_q   <= valid_f_d;
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .load_i  (id_load_c),
        .clear_i (id_clear_c),
        .valid_i (id_valid_in_c),
        .instr_i (imem_rdata),
        .pc_i    (pc_f_q),
        .valid_o (id_valid),
        .instr_o (id_instr),
        .pc_o    (id_pc)
    );

    assign imem_addr   = addr_c;
    assign id_opcode   = id_instr[OPC_MSB:OPC_LSB];
    assign id_rd       = id_instr[RD_MSB:RD_LSB];
    assign id_rs       = id_instr[RS_MSB:RS_LSB];
    assign id_rt       = id_instr[RT_MSB:RT_LSB];
    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: word memory model, scoreboard of expected ID
// deliveries, plus a second instance with RESET_PC at the top of the space.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [3:0]  id_opcode;
    logic [5:0]  id_rd, id_rs, id_rt;
    logic [31:0] fetch_count, flush_count;

    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_id_valid;
    logic [31:0] w_id_instr;
    logic [31:0] w_id_pc;
    logic [3:0]  w_id_opcode;
    logic [5:0]  w_id_rd, w_id_rs, w_id_rt;
    logic [31:0] w_fetch_count, w_flush_count;

    logic        patch0;
    logic        sb_en;
    logic [63:0] sb_q[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    fetch_stage u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_opcode   (id_opcode),
        .id_rd       (id_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .fetch_count (fetch_count),
        .flush_count (flush_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
        .clock       (clock),
        .reset_n     (reset_n),
        .stall       (w_stall),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .imem_addr   (w_imem_addr),
        .imem_rdata  (w_imem_rdata),
        .id_valid    (w_id_valid),
        .id_instr    (w_id_instr),
        .id_pc       (w_id_pc),
        .id_opcode   (w_id_opcode),
        .id_rd       (w_id_rd),
        .id_rs       (w_id_rs),
        .id_rt       (w_id_rt),
        .fetch_count (w_fetch_count),
        .flush_count (w_flush_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (patch0 && a == 32'h0) return 32'h50C2_0C00;
        return 32'hA000_0000 + a;
    endfunction

    // Synchronous memories with one-cycle read latency.
    always @(posedge clock) begin
        imem_rdata   <= mem_word(imem_addr);
        w_imem_rdata <= mem_word(w_imem_addr);
    end

    function automatic logic [63:0] exp_entry(input logic [31:0] pc);
        return {pc, mem_word(pc)};
    endfunction

    // One clock; on an edge that should load ID, pop the scoreboard.
    task automatic tick();
        logic        le;
        logic [63:0] exp;
        le = sb_en && reset_n && !stall && !redirect;
        @(posedge clock);
        @(negedge clock);
        if (le && id_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, none expected", id_pc, id_instr);
            end else begin
                exp = sb_q.pop_front();
                if ({id_pc, id_instr} !== exp) begin
                    errors++;
                    $display("FAIL sb_id: got pc=%h instr=%h want pc=%h instr=%h",
                             id_pc, id_instr, exp[63:32], exp[31:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid); end
        checks++; if ({id_instr, id_pc} !== 64'h0) begin errors++; $display("FAIL rst_id: got %h/%h want 0", id_instr, id_pc); end
        checks++; if ({id_opcode, id_rd, id_rs, id_rt} !== 22'h0) begin errors++; $display("FAIL rst_fields: got nonzero want 0"); end
        checks++; if ({fetch_count, flush_count} !== 64'h0) begin errors++; $display("FAIL rst_counts: got %h/%h want 0", fetch_count, flush_count); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        checks++; if (w_imem_addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_waddr: got %h want ffffffff", w_imem_addr); end
    endtask

    task automatic test_sequential();
        sb_en = 1'b1;
        for (int i = 0; i < 3; i++) sb_q.push_back(exp_entry(32'(i)));
        reset_n = 1'b1;
        #1;
        for (int e = 1; e <= 4; e++) begin
            checks++;
            if (imem_addr !== 32'(e - 1)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", e, imem_addr, e - 1); end
            tick();
            checks++;
            if (id_valid !== (e >= 2)) begin errors++; $display("FAIL seq_valid%0d: got %b want %b", e, id_valid, e >= 2); end
        end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL seq_fcount: got %0d want 3", fetch_count); end
        checks++; if (id_pc !== 32'd2) begin errors++; $display("FAIL seq_pc: got %h want 2", id_pc); end
    endtask

    task automatic test_stall();
        sb_q.push_back(exp_entry(32'd3));
        sb_q.push_back(exp_entry(32'd4));
        tick();
        tick();
        stall = 1'b1;
        #1;
        checks++; if (imem_addr !== 32'd5) begin errors++; $display("FAIL stall_addr0: got %h want 5", imem_addr); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 32'd4, 32'hA000_0004, 32'd5}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h addr=%h want 1/4/a0000004/5", c, id_valid, id_pc, id_instr, imem_addr);
            end
            checks++;
            if ({fetch_count, flush_count} !== {32'd5, 32'd0}) begin
                errors++;
                $display("FAIL stall_cnt%0d: got %0d/%0d want 5/0", c, fetch_count, flush_count);
            end
        end
        stall = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'd6) begin errors++; $display("FAIL stall_rel_addr: got %h want 6", imem_addr); end
        sb_q.push_back(exp_entry(32'd5));
        sb_q.push_back(exp_entry(32'd6));
        tick();
        checks++; if (id_pc !== 32'd5) begin errors++; $display("FAIL stall_rel_pc5: got %h want 5", id_pc); end
        tick();
        checks++; if (id_pc !== 32'd6) begin errors++; $display("FAIL stall_rel_pc6: got %h want 6", id_pc); end
    endtask

    task automatic test_redirect();
        sb_q.push_back(exp_entry(32'd7));
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr: got %h want 40", imem_addr); end
        tick();
        redirect = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble: got %b want 0", id_valid); end
        checks++; if ({flush_count, fetch_count} !== {32'd1, 32'd8}) begin errors++; $display("FAIL redir_cnt: got %0d/%0d want 1/8", flush_count, fetch_count); end
        sb_q.push_back(exp_entry(32'h40));
        tick();
        checks++; if ({id_valid, id_pc} !== {1'b1, 32'h40}) begin errors++; $display("FAIL redir_target: got %b/%h want 1/40", id_valid, id_pc); end
        checks++; if (fetch_count !== 32'd9) begin errors++; $display("FAIL redir_fcount: got %0d want 9", fetch_count); end
    endtask

    task automatic test_redirect_stall();
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h10;
        #1;
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL rs_addr: got %h want 10", imem_addr); end
        tick();
        redirect = 1'b0;
        #1;
        checks++; if ({id_valid, flush_count} !== {1'b0, 32'd2}) begin errors++; $display("FAIL rs_flush: got %b/%0d want 0/2", id_valid, flush_count); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL rs_refetch: got %h want 10", imem_addr); end
        tick();
        checks++; if ({id_valid, fetch_count} !== {1'b0, 32'd9}) begin errors++; $display("FAIL rs_hold: got %b/%0d want 0/9", id_valid, fetch_count); end
        stall = 1'b0;
        sb_q.push_back(exp_entry(32'h10));
        tick();
        checks++; if ({id_valid, id_pc, fetch_count} !== {1'b1, 32'h10, 32'd10}) begin errors++; $display("FAIL rs_target: got %b/%h/%0d want 1/10/10", id_valid, id_pc, fetch_count); end
    endtask

    task automatic test_mid_reset();
        redirect    = 1'b1;
        redirect_pc = 32'd8;
        tick();
        redirect = 1'b0;
        checks++; if (flush_count !== 32'd3) begin errors++; $display("FAIL mr_flush: got %0d want 3", flush_count); end
        sb_q.push_back(exp_entry(32'd8));
        sb_q.push_back(exp_entry(32'd9));
        tick();
        tick();
        checks++; if ({id_valid, id_pc} !== {1'b1, 32'd9}) begin errors++; $display("FAIL mr_pre: got %b/%h want 1/9", id_valid, id_pc); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({id_valid, id_instr, id_pc} !== 65'h0) begin errors++; $display("FAIL mr_id: got %b/%h/%h want 0", id_valid, id_instr, id_pc); end
        checks++; if ({id_opcode, id_rd, id_rs, id_rt} !== 22'h0) begin errors++; $display("FAIL mr_fields: got nonzero want 0"); end
        checks++; if ({fetch_count, flush_count} !== 64'h0) begin errors++; $display("FAIL mr_cnt: got %0d/%0d want 0/0", fetch_count, flush_count); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mr_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_restart_fields();
        patch0 = 1'b1;
        tick();
        reset_n = 1'b1;
        sb_q.push_back(exp_entry(32'd0));
        sb_q.push_back(exp_entry(32'd1));
        tick();
        checks++; if ({id_valid, imem_addr} !== {1'b0, 32'd1}) begin errors++; $display("FAIL rf_boot: got %b/%h want 0/1", id_valid, imem_addr); end
        tick();
        checks++; if ({id_valid, id_instr} !== {1'b1, 32'h50C2_0C00}) begin errors++; $display("FAIL rf_instr: got %b/%h want 1/50c20c00", id_valid, id_instr); end
        checks++; if ({id_opcode, id_rd, id_rs, id_rt} !== {4'd5, 6'd3, 6'd2, 6'd3}) begin errors++; $display("FAIL rf_fields: got %0d/%0d/%0d/%0d want 5/3/2/3", id_opcode, id_rd, id_rs, id_rt); end
        tick();
        checks++; if ({id_pc, fetch_count} !== {32'd1, 32'd2}) begin errors++; $display("FAIL rf_next: got %h/%0d want 1/2", id_pc, fetch_count); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size()); end
    endtask

    task automatic test_wrap();
        sb_en   = 1'b0;
        patch0  = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (w_id_valid !== 1'b0) begin errors++; $display("FAIL wrap_boot: got %b want 0", w_id_valid); end
        tick();
        checks++; if ({w_id_valid, w_id_pc, w_id_instr} !== {1'b1, 32'hFFFF_FFFF, 32'h9FFF_FFFF}) begin errors++; $display("FAIL wrap_top: got %b/%h/%h want 1/ffffffff/9fffffff", w_id_valid, w_id_pc, w_id_instr); end
        tick();
        checks++; if ({w_id_valid, w_id_pc, w_id_instr} !== {1'b1, 32'h0, 32'hA000_0000}) begin errors++; $display("FAIL wrap_zero: got %b/%h/%h want 1/0/a0000000", w_id_valid, w_id_pc, w_id_instr); end
    endtask

    initial begin
        reset_n       = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        w_stall       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        patch0        = 1'b0;
        sb_en         = 1'b0;
        tick();
        tick();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_mid_reset();
        test_restart_fields();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with its IF/ID pipeline register; directly upstream of the decode stage.
- Owns the word-addressed PC and drives a synchronous instruction memory, 1-cycle read latency.
- Accepts redirects (branch/jump target from WB) and stalls.
- Presents a valid-tagged instruction, its PC, and pre-split fields to decode.

Parameters:
- ADDR_W, 32, PC / instruction-address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID register (decode not ready).
- redirect  in  1  take redirect_pc; driven from WB (branchZero&z | branchNeg&n | jump).
- redirect_pc  in  ADDR_W  branch/jump target.
- imem_addr  out  ADDR_W  address latched by the instruction memory on the next rising edge.
- imem_rdata  in  INSTR_W  memory data for the address latched at the previous edge.
- id_valid  out  1  IF/ID register holds a real instruction.
- id_instr  out  INSTR_W  registered instruction.
- id_pc  out  ADDR_W  PC of id_instr.
- id_opcode  out  4  id_instr[31:28].
- id_rd  out  6  id_instr[27:22].
- id_rs  out  6  id_instr[21:16].
- id_rt  out  6  id_instr[15:10].
- fetch_count  out  32  valid instructions delivered to ID.
- flush_count  out  32  fetch slots killed by redirect.

Behaviour:
- State machine, 2 states:
  - BOOT (reset state): imem_addr = RESET_PC; next edge -> RUN with pc_f = RESET_PC, valid_f = 1.
  - RUN: normal fetch. There is no path back to BOOT except reset.
- Internal registers:
  - pc_f: address whose data is on imem_rdata this cycle.
  - valid_f: that data is a wanted fetch.
- imem_addr is combinational; pc_f <= imem_addr every edge. Selection in RUN, highest priority first:
  - redirect: redirect_pc.
  - stall: pc_f (re-fetch, so imem_rdata stays stable).
  - otherwise: pc_f + 1, wrapping modulo 2^ADDR_W with no flag.
- IF/ID register update per edge:
  - redirect=1: id_valid <= 0. id_instr/id_pc are don't-care but load imem_rdata/pc_f. valid_f <= 1 (the new target fetch is good). flush_count += 1 if valid_f was 1 or id_valid was 1.
  - redirect=0, stall=1: all ID outputs hold; pc_f holds; counters hold.
  - otherwise: id_instr <= imem_rdata, id_pc <= pc_f, id_valid <= valid_f. fetch_count += 1 when valid_f = 1.
  - BOOT: id_valid <= 0.
- Redirect overrides a simultaneous stall. Redirect to the current pc_f is legal and still flushes.
- Counters wrap at 2^32.
- Latency:
  - Reset release -> first id_valid=1 after the second rising edge (BOOT edge, then the RUN edge that loads ID).
  - Redirect at edge E -> target instruction in ID after edge E+1; exactly one bubble.
- Asynchronous reset (reset_n=0, any time including mid-stall or mid-redirect):
  - state = BOOT, pc_f = RESET_PC, valid_f = 0.
  - id_valid = 0, id_instr = 0, id_pc = 0, fields = 0.
  - fetch_count = 0, flush_count = 0.
  - imem_addr = RESET_PC while in reset.
- id_opcode/id_rd/id_rs/id_rt are pure slices of the registered id_instr; no extra latency.
- Stall during BOOT is ignored; BOOT always advances.

Decomposition:
- Shared package (cpu_pkg):
  - Instruction field positions: OPC_MSB 31, OPC_LSB 28, RD 27:22, RS 21:16, RT 15:10.
  - OPCODE_W 4, REG_ADDR_W 6.
  - Default RESET_PC.
  - FSM state encoding BOOT=1'b0, RUN=1'b1.
- One natural sub-module, if_id_reg: the valid-tagged, stall/flush-capable IF/ID pipeline register with async active-low reset.
- PC selection and the counters stay in fetch_stage.

Test Plan:
- Reset and sequential fetch: memory mem[i] = 32'hA000_0000 + i; release reset_n, no stall/redirect. Expect imem_addr 0,1,2,3 on successive edges; id_valid=1 from the 2nd edge; id_pc 0,1,2 with id_instr A0000000, A0000001, A0000002; fetch_count=3 after the 4th edge.
- Field slicing: mem[0] = 32'h5_0C2_0C00 pattern (opcode 5, rd 3, rs 2, rt 3). Expect id_opcode=5, id_rd=3, id_rs=2, id_rt=3.
- Stall: assert stall for 3 cycles while id_pc=4. Expect id_pc=4, id_instr and imem_addr constant (5), counters frozen; after release, id_pc 5, then 6 on consecutive edges.
- Redirect: pulse redirect with redirect_pc=32'h40 while id_pc=7. Expect id_valid=0 for one cycle; next edge id_pc=0x40, id_valid=1; flush_count=1.
- Redirect and stall together, redirect_pc=32'h10: redirect wins; imem_addr=0x10, id_valid=0, then id_pc=0x10 even though stall remains high for that edge only if stall is released (stall held -> id_pc holds 0x10 after loading).
- Mid-operation reset: drop reset_n asynchronously between edges at id_pc=9. Expect all outputs zero and imem_addr=0 immediately (no edge); restart matches the first scenario. Also wrap: RESET_PC=32'hFFFF_FFFF yields id_pc FFFFFFFF then 0.
